// File: rtl/cmp_arbiter_if.sv
// Requester-side bus of the shared comparator arbiter: request/operand inputs
// plus the grant pulse and tagged one-hot result.
interface cmp_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] a_in;
    logic [NUM_REQ*16-1:0] b_in;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic                  gt;
    logic                  lt;
    logic                  eq;

    modport master (
        output req, a_in, b_in,
        input  grant, busy, rsp_valid, rsp_id, gt, lt, eq
    );

    modport slave (
        input  req, a_in, b_in,
        output grant, busy, rsp_valid, rsp_id, gt, lt, eq
    );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one 16-bit unsigned magnitude comparator among
// NUM_REQ requesters; two-state IDLE/CMP sequencer with registered outputs.
module cmp_mag16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gt,
    output logic        lt,
    output logic        eq
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

module cmp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input logic          clk,
    input logic          rst,
    cmp_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CMP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [15:0]        a_reg_q, a_reg_d;
    logic [15:0]        b_reg_q, b_reg_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic               cmp_gt, cmp_lt, cmp_eq;

    cmp_mag16 u_cmp (
        .a  (a_reg_q),
        .b  (b_reg_q),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    // Scan starting at ptr and wrapping; the first asserted request wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_id_d    = cur_id_q;
        a_reg_d     = a_reg_q;
        b_reg_d     = b_reg_q;
        grant_d     = '0;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    a_reg_d  = bus.a_in[int'(win_id)*16 +: 16];
                    b_reg_d  = bus.b_in[int'(win_id)*16 +: 16];
                    grant_d  = NUM_REQ'(1) << win_id;
                    busy_d   = 1'b1;
                    cur_id_d = win_id;
                    ptr_d    = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    state_d  = CMP;
                end
            end
            CMP: begin
                gt_d        = cmp_gt;
                lt_d        = cmp_lt;
                eq_d        = cmp_eq;
                rsp_valid_d = 1'b1;
                rsp_id_d    = cur_id_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cur_id_q    <= '0;
            a_reg_q     <= '0;
            b_reg_q     <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_id_q    <= cur_id_d;
            a_reg_q     <= a_reg_d;
            b_reg_q     <= b_reg_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
endmodule
